// File: rtl/pcseq_pkg.sv
// rtl/pcseq_pkg.sv - shared encodings and constants for the PC sequencer
package pcseq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT      = 2'd0,
    ST_FETCH     = 2'd1,
    ST_WAIT_NEXT = 2'd2,
    ST_HALTED    = 2'd3
  } pcseq_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_RETURN = 2'd3
  } pcseq_sel_t;

  localparam int STACK_DEPTH = 4;
  localparam int STACK_PTR_W = $clog2(STACK_DEPTH);

endpackage

// File: rtl/sc_pc_sequencer_if.sv
// rtl/sc_pc_sequencer_if.sv - instruction fetch req/ack bus between sequencer and memory
interface sc_pc_sequencer_if #(
  parameter int DATAWIDTH_BUS_PCSEQ = 11
);
  logic                           FETCH_REQ;
  logic [DATAWIDTH_BUS_PCSEQ-1:0] FETCH_ADDR;
  logic                           FETCH_ACK;

  modport master (output FETCH_REQ, output FETCH_ADDR, input FETCH_ACK);
  modport slave  (input FETCH_REQ, input FETCH_ADDR, output FETCH_ACK);
endinterface

// File: rtl/sc_pcseq_retstack.sv
// rtl/sc_pcseq_retstack.sv - 4-entry circular return-address stack (built only with PCSEQ_RETURN_STACK_EN)
`ifdef PCSEQ_RETURN_STACK_EN
module sc_pcseq_retstack
  import pcseq_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic         err
);
  localparam logic [STACK_PTR_W-1:0] PTR_ONE = STACK_PTR_W'(1);
  localparam logic [STACK_PTR_W:0]   CNT_ONE = (STACK_PTR_W + 1)'(1);
  localparam logic [STACK_PTR_W:0]   CNT_MAX = (STACK_PTR_W + 1)'(STACK_DEPTH);

  logic [W-1:0]           mem [STACK_DEPTH];
  logic [STACK_PTR_W-1:0] top;
  logic [STACK_PTR_W:0]   count;

  // top always points at the next free slot, which is the oldest entry once full
  assign full     = (count == CNT_MAX);
  assign empty    = (count == '0);
  assign pop_data = mem[top - PTR_ONE];
  assign err      = pop && empty;

  // pointer and occupancy; a push when full wraps over the oldest entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top   <= '0;
      count <= '0;
    end else if (push) begin
      top <= top + PTR_ONE;
      if (!full) count <= count + CNT_ONE;
    end else if (pop && !empty) begin
      top   <= top - PTR_ONE;
      count <= count - CNT_ONE;
    end
  end

  // entry storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem[top] <= push_data;
  end
endmodule
`endif

// File: rtl/sc_pc_sequencer.sv
// rtl/sc_pc_sequencer.sv - PC sequencer: fetch handshake and next-PC selection (option: PCSEQ_RETURN_STACK_EN)
module sc_pc_sequencer
  import pcseq_pkg::*;
#(
  parameter int                             DATAWIDTH_BUS_PCSEQ = 11,
  parameter logic [DATAWIDTH_BUS_PCSEQ-1:0] RESET_VECTOR        = 11'h000,
  parameter logic [DATAWIDTH_BUS_PCSEQ-1:0] TRAP_VECTOR         = 11'h400
) (
  input  logic                           SC_PCSEQ_CLOCK_50,
  input  logic                           SC_PCSEQ_RESET_InLow,
  sc_pc_sequencer_if.master              fetch,
  input  logic                           NEXT_VALID,
  input  logic [1:0]                     NEXT_SEL,
  input  logic                           BRANCH_TAKEN,
  input  logic                           CALL,
  input  logic [DATAWIDTH_BUS_PCSEQ-1:0] TARGET,
  input  logic                           STALL,
  input  logic                           TRAP,
  input  logic                           HALT,
  output logic [DATAWIDTH_BUS_PCSEQ-1:0] PC_OUT,
  output logic [DATAWIDTH_BUS_PCSEQ-1:0] EPC_OUT,
  output logic [1:0]                     STATE_OUT,
  output logic                           STACK_ERR
);
  localparam int           W   = DATAWIDTH_BUS_PCSEQ;
  localparam logic [W-1:0] ONE = W'(1);

  pcseq_state_t state;
  logic [W-1:0] pc, epc, pc_inc, next_pc, ret_pc;
  logic         req, trap_pending;
  logic         trap_req, take_trap, go_halt, accept, do_push, do_pop;

  assign pc_inc    = pc + ONE;
  assign trap_req  = TRAP || trap_pending;
  assign take_trap = (state == ST_WAIT_NEXT && trap_req) || (state == ST_HALTED && TRAP);
  assign go_halt   = (state == ST_WAIT_NEXT) && !trap_req && HALT && NEXT_VALID;
  assign accept    = (state == ST_WAIT_NEXT) && !trap_req && !HALT && !STALL && NEXT_VALID;
  assign do_push   = accept && (NEXT_SEL == SEL_JUMP) && CALL;
  assign do_pop    = accept && (NEXT_SEL == SEL_RETURN);

`ifdef PCSEQ_RETURN_STACK_EN
  logic [W-1:0] stk_data;
  logic         stk_full, stk_empty, stk_err, stack_err;
  logic         unused_full;

  sc_pcseq_retstack #(.W(W)) u_retstack (
    .clk       (SC_PCSEQ_CLOCK_50),
    .rst_n     (SC_PCSEQ_RESET_InLow),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (pc_inc),
    .pop_data  (stk_data),
    .full      (stk_full),
    .empty     (stk_empty),
    .err       (stk_err)
  );

  assign unused_full = stk_full;
  assign ret_pc      = stk_empty ? RESET_VECTOR : stk_data;

  // one-cycle error pulse when a return finds the stack empty
  always_ff @(posedge SC_PCSEQ_CLOCK_50 or negedge SC_PCSEQ_RESET_InLow) begin
    if (!SC_PCSEQ_RESET_InLow) stack_err <= 1'b0;
    else                       stack_err <= stk_err;
  end
  assign STACK_ERR = stack_err;
`else
  logic unused_ctl;
  assign unused_ctl = CALL ^ do_push ^ do_pop;
  assign ret_pc     = pc_inc;
  assign STACK_ERR  = 1'b0;
`endif

  // next-PC selection for an accepted decode decision; all sums wrap modulo 2^W
  always_comb begin
    next_pc = pc_inc;
    case (NEXT_SEL)
      SEL_SEQ:    next_pc = pc_inc;
      SEL_BRANCH: next_pc = BRANCH_TAKEN ? (pc + TARGET) : pc_inc;
      SEL_JUMP:   next_pc = TARGET;
      SEL_RETURN: next_pc = ret_pc;
      default:    next_pc = pc_inc;
    endcase
  end

  // sequencing FSM; a trap seen mid-fetch is parked until the fetch completes
  always_ff @(posedge SC_PCSEQ_CLOCK_50 or negedge SC_PCSEQ_RESET_InLow) begin
    if (!SC_PCSEQ_RESET_InLow) begin
      state        <= ST_BOOT;
      pc           <= RESET_VECTOR;
      epc          <= '0;
      req          <= 1'b0;
      trap_pending <= 1'b0;
    end else if (take_trap) begin
      epc          <= pc_inc;
      pc           <= TRAP_VECTOR;
      trap_pending <= 1'b0;
      req          <= 1'b1;
      state        <= ST_FETCH;
    end else begin
      case (state)
        ST_BOOT: begin
          if (TRAP) trap_pending <= 1'b1;
          req   <= 1'b1;
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (TRAP) trap_pending <= 1'b1;
          if (fetch.FETCH_ACK) begin
            req   <= 1'b0;
            state <= ST_WAIT_NEXT;
          end
        end
        ST_WAIT_NEXT: begin
          if (go_halt) begin
            state <= ST_HALTED;
          end else if (accept) begin
            pc    <= next_pc;
            req   <= 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_HALTED: req <= 1'b0;
        default:   state <= ST_BOOT;
      endcase
    end
  end

  assign fetch.FETCH_REQ  = req;
  assign fetch.FETCH_ADDR = pc;
  assign PC_OUT           = pc;
  assign EPC_OUT          = epc;
  assign STATE_OUT        = state;
endmodule

// File: tb/tb_sc_pc_sequencer.sv
// tb/tb_sc_pc_sequencer.sv - scoreboard bench for sc_pc_sequencer
module tb_sc_pc_sequencer;
  import pcseq_pkg::*;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         next_valid, branch_taken, call, stall, trap, halt;
  logic [1:0]   next_sel;
  logic [W-1:0] target;
  logic [W-1:0] pc_out, epc_out;
  logic [1:0]   state_out;
  logic         stack_err;

  int           n_checks = 0;
  int           n_pass = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  sc_pc_sequencer_if #(.DATAWIDTH_BUS_PCSEQ(W)) fb ();

  sc_pc_sequencer dut (
    .SC_PCSEQ_CLOCK_50    (clk),
    .SC_PCSEQ_RESET_InLow (rst_n),
    .fetch                (fb.master),
    .NEXT_VALID           (next_valid),
    .NEXT_SEL             (next_sel),
    .BRANCH_TAKEN         (branch_taken),
    .CALL                 (call),
    .TARGET               (target),
    .STALL                (stall),
    .TRAP                 (trap),
    .HALT                 (halt),
    .PC_OUT               (pc_out),
    .EPC_OUT              (epc_out),
    .STATE_OUT            (state_out),
    .STACK_ERR            (stack_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // memory side: wait for a request, compare against the scoreboard, ack after delay cycles
  task automatic do_fetch(input int delay, input bit trap_in_delay);
    int           n = 0;
    logic [W-1:0] exp = '0;
    logic [W-1:0] addr0;
    while (fb.FETCH_REQ !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("fetch_req_seen", 32'(fb.FETCH_REQ), 32'd1);
    check_eq("fetch_state", 32'(state_out), 32'(ST_FETCH));
    check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    addr0 = fb.FETCH_ADDR;
    check_eq("fetch_addr", 32'(addr0), 32'(exp));
    for (int i = 0; i < delay; i++) begin
      if (trap_in_delay && i == 0) trap = 1'b1;
      @(negedge clk);
      trap = 1'b0;
      check_eq("req_held", 32'(fb.FETCH_REQ), 32'd1);
      check_eq("addr_stable", 32'(fb.FETCH_ADDR), 32'(addr0));
    end
    fb.FETCH_ACK = 1'b1;
    @(negedge clk);
    fb.FETCH_ACK = 1'b0;
    check_eq("req_drop", 32'(fb.FETCH_REQ), 32'd0);
    check_eq("wait_state", 32'(state_out), 32'(ST_WAIT_NEXT));
  endtask

  // decode side: present one decision and predict the resulting PC
  task automatic decide(input logic [1:0] sel, input logic taken, input logic is_call,
                        input logic [W-1:0] tgt, input logic [W-1:0] exp_pc, input logic exp_err);
    next_valid   = 1'b1;
    next_sel     = sel;
    branch_taken = taken;
    call         = is_call;
    target       = tgt;
    exp_q.push_back(exp_pc);
    @(negedge clk);
    next_valid   = 1'b0;
    branch_taken = 1'b0;
    call         = 1'b0;
    check_eq("dec_state", 32'(state_out), 32'(ST_FETCH));
    check_eq("dec_pc", 32'(pc_out), 32'(exp_pc));
    check_eq("dec_stack_err", 32'(stack_err), 32'(exp_err));
  endtask

  task automatic jump_to(input logic [W-1:0] addr);
    decide(SEL_JUMP, 1'b0, 1'b0, addr, addr, 1'b0);
    do_fetch(0, 1'b0);
  endtask

  initial begin
    next_valid = 0; branch_taken = 0; call = 0; stall = 0; trap = 0; halt = 0;
    next_sel = 2'b00; target = '0; fb.FETCH_ACK = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_pc", 32'(pc_out), 32'h000);
    check_eq("rst_req", 32'(fb.FETCH_REQ), 32'd0);
    check_eq("rst_state", 32'(state_out), 32'(ST_BOOT));
    check_eq("rst_epc", 32'(epc_out), 32'h000);
    check_eq("rst_stack_err", 32'(stack_err), 32'd0);
    rst_n = 1'b1;

    exp_q.push_back(11'h000);
    do_fetch(0, 1'b0);
    decide(SEL_SEQ, 1'b0, 1'b0, '0, 11'h001, 1'b0);
    do_fetch(0, 1'b0);
    decide(SEL_SEQ, 1'b0, 1'b0, '0, 11'h002, 1'b0);
    do_fetch(0, 1'b0);

    jump_to(11'h7FF);
    decide(SEL_SEQ, 1'b0, 1'b0, '0, 11'h000, 1'b0);
    do_fetch(0, 1'b0);

    jump_to(11'h010);
    decide(SEL_BRANCH, 1'b1, 1'b0, 11'h7FE, 11'h00E, 1'b0);
    do_fetch(0, 1'b0);
    jump_to(11'h010);
    decide(SEL_BRANCH, 1'b0, 1'b0, 11'h7FE, 11'h011, 1'b0);
    do_fetch(0, 1'b0);
    decide(SEL_BRANCH, 1'b1, 1'b0, 11'h7F0, 11'h001, 1'b0);
    do_fetch(0, 1'b0);

    next_valid = 1'b1; next_sel = SEL_JUMP; target = 11'h123; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_state", 32'(state_out), 32'(ST_WAIT_NEXT));
      check_eq("stall_pc", 32'(pc_out), 32'h001);
    end
    stall = 1'b0;
    exp_q.push_back(11'h123);
    @(negedge clk);
    next_valid = 1'b0;
    check_eq("unstall_pc", 32'(pc_out), 32'h123);
    do_fetch(0, 1'b0);

    decide(SEL_JUMP, 1'b0, 1'b0, 11'h020, 11'h020, 1'b0);
    do_fetch(3, 1'b1);
    exp_q.push_back(11'h400);
    @(negedge clk);
    check_eq("trap_state", 32'(state_out), 32'(ST_FETCH));
    check_eq("trap_pc", 32'(pc_out), 32'h400);
    check_eq("trap_epc", 32'(epc_out), 32'h021);
    do_fetch(0, 1'b0);

    jump_to(11'h030);
    next_valid = 1'b1; halt = 1'b1; next_sel = SEL_SEQ;
    @(negedge clk);
    next_valid = 1'b0; halt = 1'b0;
    check_eq("halt_state", 32'(state_out), 32'(ST_HALTED));
    check_eq("halt_pc", 32'(pc_out), 32'h030);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("halt_req_low", 32'(fb.FETCH_REQ), 32'd0);
    end
    trap = 1'b1;
    exp_q.push_back(11'h400);
    @(negedge clk);
    trap = 1'b0;
    check_eq("halt_trap_state", 32'(state_out), 32'(ST_FETCH));
    check_eq("halt_trap_epc", 32'(epc_out), 32'h031);
    do_fetch(0, 1'b0);

`ifdef PCSEQ_RETURN_STACK_EN
    jump_to(11'h050);
    decide(SEL_JUMP, 1'b0, 1'b1, 11'h100, 11'h100, 1'b0);
    do_fetch(0, 1'b0);
    decide(SEL_RETURN, 1'b0, 1'b0, '0, 11'h051, 1'b0);
    do_fetch(0, 1'b0);
    decide(SEL_RETURN, 1'b0, 1'b0, '0, 11'h000, 1'b1);
    @(negedge clk);
    check_eq("stack_err_once", 32'(stack_err), 32'd0);
    do_fetch(0, 1'b0);
`else
    decide(SEL_JUMP, 1'b0, 1'b1, 11'h200, 11'h200, 1'b0);
    do_fetch(0, 1'b0);
    decide(SEL_RETURN, 1'b0, 1'b0, '0, 11'h201, 1'b0);
    do_fetch(0, 1'b0);
`endif

    decide(SEL_SEQ, 1'b0, 1'b0, '0, pc_out + 11'd1, 1'b0);
    check_eq("sb_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_req", 32'(fb.FETCH_REQ), 32'd0);
    check_eq("async_rst_state", 32'(state_out), 32'(ST_BOOT));
    check_eq("async_rst_pc", 32'(pc_out), 32'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
